// File: rtl/udma_hyper_pkg.sv
// Shared types and helpers for the HyperBus transaction scheduler.
// rr_pick supports up to RR_MAX_CH requesters; callers zero-extend narrower vectors.
package udma_hyper_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        EOT   = 2'd3
    } sched_state_e;

    localparam int TO_W_DEFAULT = 16;
    localparam int RR_MAX_CH    = 8;

    // First set bit of req at or after ptr, wrapping at nb_ch; 0 when req is empty.
    function automatic logic [2:0] rr_pick(input logic [RR_MAX_CH-1:0] req,
                                           input logic [2:0]           ptr,
                                           input int                   nb_ch);
        logic [2:0] pick;
        logic       found;
        int         idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < RR_MAX_CH; i++) begin
            idx = int'(ptr) + i;
            if (idx >= nb_ch) idx = idx - nb_ch;
            if (i < nb_ch && !found && req[idx[2:0]]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/udma_hyper_toggle_sync.sv
// Brings a toggle-encoded event from another clock domain into clk_i and
// turns each toggle into a single-cycle pulse.
module udma_hyper_toggle_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic tgl_i,
    output logic pulse_o
);

    logic s1, s2, s3;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= tgl_i;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign pulse_o = s2 ^ s3;

endmodule

// File: rtl/udma_hyper_trans_sched.sv
// Round-robin scheduler sharing one HyperBus PHY between NB_CH uDMA channels.
// trans_valid_o/trans_ready_i: valid rises with the grant and stays high until the ready cycle.
module udma_hyper_trans_sched
    import udma_hyper_pkg::*;
#(
    parameter int  NB_CH = 2,
    parameter int  TO_W  = TO_W_DEFAULT,
    localparam int ID_W  = (NB_CH > 1) ? $clog2(NB_CH) : 1
) (
    input  logic             sys_clk_i,
    input  logic             rst_ni,
    input  logic [NB_CH-1:0] req_i,
    output logic [NB_CH-1:0] ack_o,
    output logic [ID_W-1:0]  gnt_id_o,
    output logic             trans_valid_o,
    input  logic             trans_ready_i,
    input  logic             phy_done_tgl_i,
    input  logic [TO_W-1:0]  timeout_i,
    output logic [NB_CH-1:0] busy_o,
    output logic [NB_CH-1:0] evt_eot_o,
    output logic             err_to_o
);

    localparam logic [NB_CH-1:0] ONE = NB_CH'(1);

    sched_state_e     state;
    logic [ID_W-1:0]  rr_ptr;
    logic [TO_W-1:0]  to_cnt;
    logic             to_en;
    logic             done;
    logic             expire;
    logic [2:0]       win;
    logic [ID_W-1:0]  win_id;
    logic [ID_W-1:0]  nxt_ptr;
    logic [NB_CH-1:0] win_oh;
    logic [NB_CH-1:0] gnt_oh;

    udma_hyper_toggle_sync i_done_sync (
        .clk_i   (sys_clk_i),
        .rst_ni  (rst_ni),
        .tgl_i   (phy_done_tgl_i),
        .pulse_o (done)
    );

    always_comb begin
        win     = rr_pick(RR_MAX_CH'(req_i), 3'(rr_ptr), NB_CH);
        win_id  = win[ID_W-1:0];
        nxt_ptr = (win_id == ID_W'(NB_CH - 1)) ? '0 : win_id + 1'b1;
        win_oh  = ONE << win_id;
        gnt_oh  = ONE << gnt_id_o;
        // A completion in the same cycle as expiry takes precedence.
        expire  = to_en && (to_cnt == TO_W'(1)) && !done;
    end

    always_ff @(posedge sys_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            gnt_id_o      <= '0;
            ack_o         <= '0;
            busy_o        <= '0;
            trans_valid_o <= 1'b0;
            evt_eot_o     <= '0;
            err_to_o      <= 1'b0;
            to_cnt        <= '0;
            to_en         <= 1'b0;
        end else begin
            ack_o     <= '0;
            evt_eot_o <= '0;
            err_to_o  <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req_i) begin
                        gnt_id_o      <= win_id;
                        ack_o         <= win_oh;
                        busy_o        <= busy_o | win_oh;
                        rr_ptr        <= nxt_ptr;
                        trans_valid_o <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (trans_ready_i) begin
                        trans_valid_o <= 1'b0;
                        to_cnt        <= timeout_i;
                        to_en         <= |timeout_i;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    // Done pulses seen in any other state never reach this branch.
                    if (done || expire) begin
                        evt_eot_o <= gnt_oh;
                        busy_o    <= busy_o & ~gnt_oh;
                        err_to_o  <= expire;
                        state     <= EOT;
                    end else begin
                        to_cnt <= to_cnt - 1'b1;
                    end
                end
                EOT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_udma_hyper_trans_sched.sv
// Directed bench for udma_hyper_trans_sched with NB_CH=2: a transaction table plus
// hand-written sequences for timeout-disabled, stray toggle and mid-transfer reset.
module tb_udma_hyper_trans_sched;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  ack;
    logic [0:0]  gnt_id;
    logic        trans_valid;
    logic        trans_ready;
    logic        tgl;
    logic [15:0] timeout;
    logic [1:0]  busy;
    logic [1:0]  eot;
    logic        err;

    int checks = 0;
    int errors = 0;
    int eot_seen = 0;
    int err_seen = 0;
    logic [1:0] prev_ack = '0;

    udma_hyper_trans_sched #(.NB_CH(2), .TO_W(16)) dut (
        .sys_clk_i      (clk),
        .rst_ni         (rst_n),
        .req_i          (req),
        .ack_o          (ack),
        .gnt_id_o       (gnt_id),
        .trans_valid_o  (trans_valid),
        .trans_ready_i  (trans_ready),
        .phy_done_tgl_i (tgl),
        .timeout_i      (timeout),
        .busy_o         (busy),
        .evt_eot_o      (eot),
        .err_to_o       (err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // protocol monitor
    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if ($countones(busy) > 1) begin
                errors++;
                $display("FAIL busy_onehot: got %b expected at most one bit", busy);
            end
            if (ack != '0) begin
                checks++;
                if (prev_ack != '0 || $countones(ack) != 1) begin
                    errors++;
                    $display("FAIL ack_pulse: got %b (prev %b) expected single one-cycle bit", ack, prev_ack);
                end
            end
            if (eot != '0) eot_seen++;
            if (err) err_seen++;
            prev_ack = ack;
        end else begin
            prev_ack = '0;
        end
    end

    // driver tasks
    task automatic do_reset();
        rst_n       = 1'b0;
        req         = '0;
        trans_ready = 1'b0;
        tgl         = 1'b0;
        timeout     = '0;
        repeat (3) @(negedge clk);
        chk("rst_ack",   ack,         0);
        chk("rst_gnt",   gnt_id,      0);
        chk("rst_valid", trans_valid, 0);
        chk("rst_busy",  busy,        0);
        chk("rst_eot",   eot,         0);
        chk("rst_err",   err,         0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_ack(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (ack == '0 && lat < 20);
        chk("ack_seen", {31'd0, |ack}, 1);
    endtask

    task automatic wait_eot(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (eot == '0 && lat < 80);
        chk("eot_seen", {31'd0, |eot}, 1);
    endtask

    // Grant with ready already high; returns at the negedge after the handshake (in WAIT).
    task automatic grant_issue(input logic [1:0] r, input int exp_id);
        int lat;
        trans_ready = 1'b1;
        req = r;
        wait_ack(lat);
        chk("g_ack_lat", lat, 1);
        chk("g_ack", ack, 2'b01 << exp_id);
        chk("g_gnt", gnt_id, exp_id);
        chk("g_busy", busy, 2'b01 << exp_id);
        req = '0;
        @(negedge clk);
        chk("g_valid_drop", trans_valid, 0);
        trans_ready = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  req;
        bit          hold;
        int          rdy_dly;
        bit          do_tgl;
        int          tgl_dly;
        logic [15:0] to;
        int          exp_gnt;
        bit          exp_err;
    } vec_t;

    vec_t vecs[12];

    task automatic run_vec(input vec_t v);
        int lat;
        logic [1:0] exp_oh;
        exp_oh      = 2'b01 << v.exp_gnt;
        timeout     = v.to;
        trans_ready = (v.rdy_dly == 0);
        req         = v.req;
        wait_ack(lat);
        chk("ack_lat", lat, 1);
        chk("ack", ack, exp_oh);
        chk("gnt", gnt_id, v.exp_gnt);
        chk("busy_set", busy, exp_oh);
        chk("valid_set", trans_valid, 1);
        if (!v.hold) req = '0;
        for (int i = 0; i < v.rdy_dly; i++) begin
            @(negedge clk);
            chk("valid_hold", trans_valid, 1);
            chk("gnt_stable", gnt_id, v.exp_gnt);
        end
        trans_ready = 1'b1;
        @(negedge clk);
        chk("valid_drop", trans_valid, 0);
        trans_ready = 1'b0;
        if (v.do_tgl) begin
            repeat (v.tgl_dly) @(negedge clk);
            tgl = ~tgl;
            wait_eot(lat);
            chk("eot_lat", lat, 3);
        end else begin
            wait_eot(lat);
            chk("to_lat", lat, v.to);
        end
        chk("eot", eot, exp_oh);
        chk("err", err, v.exp_err);
        chk("gnt_at_eot", gnt_id, v.exp_gnt);
        @(negedge clk);
        chk("busy_clr", busy, 0);
    endtask

    initial begin
        int lat;
        int e0;
        int r0;

        //            req    hold  rdy  tgl   dly  to      gnt err
        vecs[0]  = '{2'b01, 1'b0, 0,  1'b1, 5, 16'd0,  0, 1'b0};
        vecs[1]  = '{2'b11, 1'b1, 0,  1'b1, 3, 16'd0,  1, 1'b0};
        vecs[2]  = '{2'b11, 1'b1, 0,  1'b1, 3, 16'd0,  0, 1'b0};
        vecs[3]  = '{2'b11, 1'b1, 0,  1'b1, 3, 16'd0,  1, 1'b0};
        vecs[4]  = '{2'b11, 1'b1, 0,  1'b1, 3, 16'd0,  0, 1'b0};
        vecs[5]  = '{2'b01, 1'b0, 0,  1'b1, 4, 16'd0,  0, 1'b0};
        vecs[6]  = '{2'b10, 1'b0, 10, 1'b1, 4, 16'd0,  1, 1'b0};
        vecs[7]  = '{2'b10, 1'b0, 0,  1'b1, 2, 16'd0,  1, 1'b0};
        vecs[8]  = '{2'b11, 1'b0, 0,  1'b0, 0, 16'd8,  0, 1'b1};
        vecs[9]  = '{2'b11, 1'b0, 0,  1'b1, 3, 16'd0,  1, 1'b0};
        vecs[10] = '{2'b01, 1'b0, 0,  1'b1, 5, 16'd20, 0, 1'b0};
        vecs[11] = '{2'b10, 1'b0, 3,  1'b0, 0, 16'd1,  1, 1'b1};

        do_reset();
        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // timeout disabled: stays in WAIT until the toggle
        timeout = '0;
        grant_issue(2'b01, 0);
        e0 = eot_seen;
        r0 = err_seen;
        repeat (60) @(negedge clk);
        chk("to0_no_eot", eot_seen - e0, 0);
        chk("to0_no_err", err_seen - r0, 0);
        chk("to0_busy", busy, 2'b01);
        tgl = ~tgl;
        wait_eot(lat);
        chk("to0_eot", eot, 2'b01);
        @(negedge clk);

        // stray toggle in IDLE must not complete the next transaction
        e0 = eot_seen;
        tgl = ~tgl;
        repeat (6) @(negedge clk);
        chk("stray_idle", eot_seen - e0, 0);
        grant_issue(2'b10, 1);
        repeat (20) @(negedge clk);
        chk("stray_wait", eot_seen - e0, 0);
        chk("stray_busy", busy, 2'b10);
        tgl = ~tgl;
        wait_eot(lat);
        chk("stray_eot", eot, 2'b10);
        chk("stray_eot_lat", lat, 3);
        @(negedge clk);

        // asynchronous reset during WAIT
        grant_issue(2'b01, 0);
        repeat (2) @(negedge clk);
        e0 = eot_seen;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy",  busy,        0);
        chk("arst_valid", trans_valid, 0);
        chk("arst_gnt",   gnt_id,      0);
        chk("arst_eot",   eot,         0);
        tgl = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("arst_no_eot", eot_seen - e0, 0);
        run_vec('{2'b10, 1'b0, 0, 1'b1, 4, 16'd0, 1, 1'b0});
        run_vec('{2'b11, 1'b0, 0, 1'b1, 4, 16'd0, 0, 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/udma_hyper_trans_sched.md
Name: udma_hyper_trans_sched

Overview:
Round-robin transaction scheduler that shares the single HyperBus PHY between NB_CH uDMA requesters (channel = proc ID).
- Accepts one pending request per channel and grants one transaction at a time.
- Hands the granted transaction to the PHY config path with a valid/ready handshake.
- Waits for the PHY-domain completion toggle, then raises a per-channel end-of-transfer event.
- Sits between the uDMA channel register files and the PHY clock-domain crossing; fully in sys_clk_i.

Parameters:
NB_CH, 2, number of requesting channels (2..8).
TO_W, 16, width of the completion-timeout counter.
ID_W, $clog2(NB_CH) (minimum 1), width of the granted channel ID; derived, not overridden.

Ports:
sys_clk_i  in  1  system clock.
rst_ni  in  1  reset; asynchronous, active-low.
req_i  in  NB_CH  level request per channel; held until its ack_o.
ack_o  out  NB_CH  one-cycle pulse when a channel's request is taken (grant issued).
gnt_id_o  out  ID_W  ID of the channel currently owning the PHY; the descriptor mux selects on this.
trans_valid_o  out  1  transaction issue to the PHY config path.
trans_ready_i  in  1  PHY config path accepts the issue.
phy_done_tgl_i  in  1  completion toggle from phy_clk domain; flips once per finished transaction.
timeout_i  in  TO_W  completion timeout in sys cycles; 0 disables the timeout.
busy_o  out  NB_CH  per channel: high from ack until EOT.
evt_eot_o  out  NB_CH  one-cycle end-of-transfer pulse per channel.
err_to_o  out  1  one-cycle pulse when a transaction times out.

Behaviour:
Reset values: all outputs 0; gnt_id_o=0; round-robin pointer=0; state IDLE; synchronizer flops 0.

Completion synchronizer:
- phy_done_tgl_i passes through 2 flops, plus a third flop for edge detection.
- done = s2 XOR s3.
- Latency from toggle to done: 2-3 sys cycles.

FSM states: IDLE, ISSUE, WAIT, EOT.
- IDLE: if any req_i is set, pick the first requester at or after the round-robin pointer (wrapping from NB_CH-1 to 0).
  - Set gnt_id_o to that channel, pulse its ack_o, set its busy_o.
  - Move the pointer to the winner+1, wrapping at NB_CH.
  - Go to ISSUE.
  - Arbitration is one cycle. A channel requesting alone is granted with no extra penalty.
- ISSUE: hold trans_valid_o=1 until trans_ready_i=1; on the handshake cycle go to WAIT.
  - gnt_id_o stays stable from grant until leaving EOT.
- WAIT: on done go to EOT.
  - The timeout counter is loaded with timeout_i on entry to WAIT and decrements each cycle.
  - If timeout_i≠0 and the counter reaches 1 with no done: pulse err_to_o and go to EOT (forced completion).
- EOT: pulse evt_eot_o[gnt_id_o] and clear busy_o[gnt_id_o]; next state IDLE.
  - Minimum grant-to-grant spacing is therefore ISSUE + WAIT + EOT + IDLE.

Edge and error cases:
- done arriving outside WAIT: counted as spurious and ignored; it must not generate an EOT. A toggle arriving during ISSUE is also ignored.
- Two toggles closer than 3 sys cycles are not guaranteed to be seen separately; PHY-side ordering rules this out.
- req_i dropping before ack: the request is silently withdrawn; it is never granted.
- req_i held after its ack: it re-arbitrates in the next IDLE, and round-robin gives the other channels priority.
- Simultaneous done and timeout expiry in the same cycle: done wins; no err_to_o.
- Asynchronous reset mid-transaction: all state is cleared immediately, with no EOT emitted. The PHY side must be reset by the same rst_ni.

Decomposition:
- Package udma_hyper_pkg holds:
  - sched_state_e enum (IDLE, ISSUE, WAIT, EOT; 2 bits);
  - the default TO_W constant;
  - a function rr_pick(req, ptr) returning the first-set index at or after ptr.
- One sub-module, udma_hyper_toggle_sync: 2-flop synchronizer plus edge flop, outputting the done pulse. It is reusable for other PHY→sys events.

Test Plan:
1. Reset, then req_i=01, trans_ready_i=1, toggle 5 cycles after the handshake → ack_o[0] pulses at cycle 1; busy_o=01; evt_eot_o[0] pulses 2-3 cycles after the toggle; busy_o=00.
2. Both channels requesting continuously, NB_CH=2 → grant order 0,1,0,1; each ack a single pulse; busy_o never has 2 bits set.
3. trans_ready_i held low for 10 cycles → trans_valid_o stays high and gnt_id_o stays stable; WAIT is entered only after ready.
4. timeout_i=8, no toggle → err_to_o pulses and evt_eot_o pulses; next IDLE grants normally. With timeout_i=0 and no toggle → the block stays in WAIT indefinitely.
5. Toggle arriving in IDLE, then a request → no EOT from the stray toggle; the new transaction completes only on the next toggle.
6. rst_ni asserted during WAIT → busy_o=0 and trans_valid_o=0 immediately; after release, a fresh request completes normally.
